multi_channel_clock_divider: RTL and testbench

//  Next-generation divider for the PT2262/PT2272 oscillator path. Generates N_CH independent

---
 rtl/multi_channel_clock_divider.sv | 112 +++++++++++
 tb/tb_multi_channel_clock_divider.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_clock_divider.sv
// Multi-channel programmable clock divider: N_CH independent 50%-duty divided clocks with
// per-period TICK strobes and glitch-free ratio changes and stops at period boundaries.
module multi_channel_clock_divider #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 250
) (
  input  logic                    INPUT_CLK,
  input  logic                    RST,
  input  logic [N_CH-1:0]         EN,
  input  logic [N_CH*DIV_W-1:0]   DIV,
  input  logic [N_CH-1:0]         LOAD,
  output logic [N_CH-1:0]         OUTPUT_CLK,
  output logic [N_CH-1:0]         TICK,
  output logic [N_CH*DIV_W-1:0]   ACTIVE_DIV
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [DIV_W-1:0] DefDiv = (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             out_q, out_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] div_in;
    logic [DIV_W-1:0] div_clamped;
    logic [DIV_W-1:0] half;
    logic             wrap;

    assign div_in      = DIV[g*DIV_W +: DIV_W];
    assign div_clamped = (div_in < DIV_W'(2)) ? DIV_W'(2) : div_in;
    assign half        = act_q - (act_q >> 1);
    assign wrap        = (cnt_q == act_q - DIV_W'(1));

    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      act_d      = act_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      out_d      = out_q;
      tick_d     = tick_q;
      unique case (state_q)
        StIdle: begin
          cnt_d  = '0;
          out_d  = 1'b0;
          tick_d = 1'b0;
          if (LOAD[g]) act_d = div_clamped;
          if (EN[g]) state_d = StRun;
        end
        StRun, StDrain: begin
          out_d  = (cnt_q < half);
          tick_d = wrap;
          if (wrap) begin
            cnt_d      = '0;
            pend_vld_d = 1'b0;
            // A LOAD coinciding with the boundary beats an older pending ratio.
            if (LOAD[g]) begin
              act_d = div_clamped;
            end else if (pend_vld_q) begin
              act_d = pend_q;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
            if (LOAD[g]) begin
              pend_d     = div_clamped;
              pend_vld_d = 1'b1;
            end
          end
          if (EN[g]) begin
            state_d = StRun;
          end else if (state_q == StRun) begin
            state_d = StDrain;
          end else if (wrap) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge INPUT_CLK) begin
      if (RST) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        act_q      <= DefDiv;
        pend_q     <= '0;
        pend_vld_q <= 1'b0;
        out_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        act_q      <= act_d;
        pend_q     <= pend_d;
        pend_vld_q <= pend_vld_d;
        out_q      <= out_d;
        tick_q     <= tick_d;
      end
    end

    assign OUTPUT_CLK[g]                 = out_q;
    assign TICK[g]                       = tick_q;
    assign ACTIVE_DIV[g*DIV_W +: DIV_W]  = act_q;
  end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Bench for multi_channel_clock_divider: directed scenarios plus randomized traffic, all
// checked against a period-level behavioural model of each channel.
module tb_multi_channel_clock_divider;
  localparam int N_CH  = 2;
  localparam int DIV_W = 16;
  localparam int DEF   = 250;
  localparam int VW    = N_CH * (DIV_W + 2);

  logic                  INPUT_CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [N_CH-1:0]       EN = '0;
  logic [N_CH*DIV_W-1:0] DIV = '0;
  logic [N_CH-1:0]       LOAD = '0;
  logic [N_CH-1:0]       OUTPUT_CLK;
  logic [N_CH-1:0]       TICK;
  logic [N_CH*DIV_W-1:0] ACTIVE_DIV;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = stopped, 1 = running, 2 = finishing the current period.
  int m_mode[N_CH];
  int m_pos[N_CH];
  int m_act[N_CH];
  int m_pend[N_CH];
  bit m_pvld[N_CH];
  bit m_out[N_CH];
  bit m_tick[N_CH];

  always #5 INPUT_CLK = ~INPUT_CLK;

  multi_channel_clock_divider #(
    .N_CH       (N_CH),
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEF)
  ) dut (
    .INPUT_CLK  (INPUT_CLK),
    .RST        (RST),
    .EN         (EN),
    .DIV        (DIV),
    .LOAD       (LOAD),
    .OUTPUT_CLK (OUTPUT_CLK),
    .TICK       (TICK),
    .ACTIVE_DIV (ACTIVE_DIV)
  );

  function automatic int clamp2(int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic model_edge(int c);
    int  d;
    bit  ends;
    d = int'(DIV[c*DIV_W +: DIV_W]);
    if (RST) begin
      m_mode[c] = 0; m_pos[c] = 0; m_out[c] = 0; m_tick[c] = 0;
      m_act[c] = DEF; m_pvld[c] = 0;
    end else if (m_mode[c] == 0) begin
      m_out[c] = 0; m_tick[c] = 0; m_pos[c] = 0;
      if (LOAD[c]) m_act[c] = clamp2(d);
      if (EN[c]) m_mode[c] = 1;
    end else begin
      ends      = (m_pos[c] + 1 == m_act[c]);
      m_out[c]  = (2 * m_pos[c] < m_act[c]);
      m_tick[c] = ends;
      if (ends) begin
        m_pos[c] = 0;
        if (LOAD[c]) m_act[c] = clamp2(d);
        else if (m_pvld[c]) m_act[c] = m_pend[c];
        m_pvld[c] = 0;
        m_mode[c] = EN[c] ? 1 : ((m_mode[c] == 1) ? 2 : 0);
      end else begin
        m_pos[c]++;
        if (LOAD[c]) begin
          m_pend[c] = clamp2(d);
          m_pvld[c] = 1;
        end
        m_mode[c] = EN[c] ? 1 : 2;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [N_CH-1:0]       o;
    logic [N_CH-1:0]       t;
    logic [N_CH*DIV_W-1:0] a;
    for (int c = 0; c < N_CH; c++) begin
      o[c] = m_out[c];
      t[c] = m_tick[c];
      a[c*DIV_W +: DIV_W] = DIV_W'(m_act[c]);
    end
    return {o, t, a};
  endfunction

  task automatic step();
    @(posedge INPUT_CLK);
    for (int c = 0; c < N_CH; c++) model_edge(c);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; EN = '0; LOAD = '0; DIV = '0;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = '1; LOAD = '1; DIV = '1;
    step();
    checks++;
    if (OUTPUT_CLK !== 2'b00 || TICK !== 2'b00) begin
      errors++; $display("FAIL reset_outputs: got clk=%b tick=%b exp 00 00", OUTPUT_CLK, TICK);
    end
    checks++;
    if (ACTIVE_DIV !== {16'd250, 16'd250}) begin
      errors++; $display("FAIL reset_active_div: got %h exp %h", ACTIVE_DIV, {16'd250, 16'd250});
    end
    RST = 1'b0; EN = '0; LOAD = '0; DIV = '0;
  endtask

  task automatic test_default_ratio();
    bit trace[500];
    int tk;
    do_reset();
    EN = 2'b01;
    step();
    tk = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      checks++;
      if ({OUTPUT_CLK, TICK, ACTIVE_DIV} !== exp_vec()) begin
        errors++; $display("FAIL default_model: got %h exp %h", {OUTPUT_CLK, TICK, ACTIVE_DIV}, exp_vec());
      end
      trace[i] = OUTPUT_CLK[0];
      tk += int'(TICK[0]);
      checks++;
      if (OUTPUT_CLK[1] !== 1'b0 || TICK[1] !== 1'b0) begin
        errors++; $display("FAIL idle_channel1: got clk=%b tick=%b exp 0 0", OUTPUT_CLK[1], TICK[1]);
      end
    end
    checks++;
    if (!(trace[0] && trace[124] && !trace[125] && !trace[249] && trace[250])) begin
      errors++; $display("FAIL default_shape: got %b%b%b%b%b exp 11001", trace[0], trace[124],
                         trace[125], trace[249], trace[250]);
    end
    checks++;
    if (tk !== 2) begin
      errors++; $display("FAIL default_ticks: got %0d exp 2", tk);
    end
  endtask

  task automatic test_idle_load();
    int hi;
    int tk;
    do_reset();
    DIV[15:0] = 16'd5; LOAD = 2'b01;
    step();
    LOAD = '0;
    checks++;
    if (ACTIVE_DIV[15:0] !== 16'd5) begin
      errors++; $display("FAIL idle_load_active: got %0d exp 5", ACTIVE_DIV[15:0]);
    end
    EN = 2'b01;
    step();
    hi = 0; tk = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({OUTPUT_CLK, TICK, ACTIVE_DIV} !== exp_vec()) begin
        errors++; $display("FAIL idle_load_model: got %h exp %h", {OUTPUT_CLK, TICK, ACTIVE_DIV}, exp_vec());
      end
      hi += int'(OUTPUT_CLK[0]);
      tk += int'(TICK[0]);
    end
    checks++;
    if (hi !== 12 || tk !== 4) begin
      errors++; $display("FAIL idle_load_counts: got hi=%0d tk=%0d exp hi=12 tk=4", hi, tk);
    end
  endtask

  task automatic test_ratio_change();
    logic [19:0] tr;
    do_reset();
    DIV[15:0] = 16'd8; LOAD = 2'b01; EN = 2'b01;
    step();
    LOAD = '0;
    step();
    step();
    DIV[15:0] = 16'd4; LOAD = 2'b01;
    step();
    LOAD = '0;
    checks++;
    if (ACTIVE_DIV[15:0] !== 16'd8) begin
      errors++; $display("FAIL ratio_pending_active: got %0d exp 8", ACTIVE_DIV[15:0]);
    end
    tr = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if ({OUTPUT_CLK, TICK, ACTIVE_DIV} !== exp_vec()) begin
        errors++; $display("FAIL ratio_model: got %h exp %h", {OUTPUT_CLK, TICK, ACTIVE_DIV}, exp_vec());
      end
      tr[k] = OUTPUT_CLK[0];
      if (k == 3) begin
        checks++;
        if (ACTIVE_DIV[15:0] !== 16'd8) begin
          errors++; $display("FAIL ratio_before_wrap: got %0d exp 8", ACTIVE_DIV[15:0]);
        end
      end
      if (k == 4) begin
        checks++;
        if (ACTIVE_DIV[15:0] !== 16'd4) begin
          errors++; $display("FAIL ratio_at_wrap: got %0d exp 4", ACTIVE_DIV[15:0]);
        end
      end
    end
    checks++;
    if (tr[9:0] !== 10'b1001100001) begin
      errors++; $display("FAIL ratio_shape: got %b exp 1001100001", tr[9:0]);
    end
  endtask

  task automatic test_drain();
    logic [19:0] tr;
    int          hi;
    int          tk;
    do_reset();
    DIV[15:0] = 16'd6; LOAD = 2'b01; EN = 2'b01;
    step();
    LOAD = '0;
    step();
    EN = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({OUTPUT_CLK, TICK, ACTIVE_DIV} !== exp_vec()) begin
        errors++; $display("FAIL drain_model: got %h exp %h", {OUTPUT_CLK, TICK, ACTIVE_DIV}, exp_vec());
      end
    end
    checks++;
    if (TICK[0] !== 1'b1 || OUTPUT_CLK[0] !== 1'b0) begin
      errors++; $display("FAIL drain_final_tick: got tick=%b clk=%b exp 1 0", TICK[0], OUTPUT_CLK[0]);
    end
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      hi += int'(OUTPUT_CLK[0]) + int'(TICK[0]);
    end
    checks++;
    if (hi !== 0) begin
      errors++; $display("FAIL drain_held_low: got %0d active cycles exp 0", hi);
    end
    EN = 2'b01;
    step();
    tr = '0; tk = 0;
    for (int k = 0; k < 12; k++) begin
      EN = (k == 2 || k == 3) ? 2'b00 : 2'b01;
      step();
      checks++;
      if ({OUTPUT_CLK, TICK, ACTIVE_DIV} !== exp_vec()) begin
        errors++; $display("FAIL reraise_model: got %h exp %h", {OUTPUT_CLK, TICK, ACTIVE_DIV}, exp_vec());
      end
      tr[k] = OUTPUT_CLK[0];
      tk += int'(TICK[0]);
    end
    checks++;
    if (tr[11:0] !== 12'b000111000111 || tk !== 2) begin
      errors++; $display("FAIL reraise_shape: got %b tk=%0d exp 000111000111 tk=2", tr[11:0], tk);
    end
  endtask

  task automatic test_clamp();
    logic [19:0] t0;
    logic [19:0] t1;
    do_reset();
    DIV = {16'd1, 16'd0}; LOAD = 2'b11;
    step();
    LOAD = '0;
    checks++;
    if (ACTIVE_DIV !== {16'd2, 16'd2}) begin
      errors++; $display("FAIL clamp_active: got %h exp %h", ACTIVE_DIV, {16'd2, 16'd2});
    end
    EN = 2'b11;
    step();
    t0 = '0; t1 = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({OUTPUT_CLK, TICK, ACTIVE_DIV} !== exp_vec()) begin
        errors++; $display("FAIL clamp_model: got %h exp %h", {OUTPUT_CLK, TICK, ACTIVE_DIV}, exp_vec());
      end
      t0[k] = OUTPUT_CLK[0];
      t1[k] = OUTPUT_CLK[1];
    end
    checks++;
    if (t0[9:0] !== 10'b0101010101 || t1[9:0] !== 10'b0101010101) begin
      errors++; $display("FAIL clamp_shape: got %b %b exp 0101010101", t0[9:0], t1[9:0]);
    end
  endtask

  task automatic test_reset_mid();
    int hi;
    do_reset();
    DIV[31:16] = 16'd7; LOAD = 2'b10;
    step();
    LOAD = '0;
    checks++;
    if (ACTIVE_DIV[31:16] !== 16'd7) begin
      errors++; $display("FAIL mid_preload: got %0d exp 7", ACTIVE_DIV[31:16]);
    end
    EN = 2'b01;
    for (int i = 0; i < 61; i++) step();
    checks++;
    if (OUTPUT_CLK[0] !== 1'b1) begin
      errors++; $display("FAIL mid_high_phase: got %b exp 1", OUTPUT_CLK[0]);
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++;
    if (OUTPUT_CLK !== 2'b00 || TICK !== 2'b00 || ACTIVE_DIV !== {16'd250, 16'd250}) begin
      errors++; $display("FAIL mid_reset: got clk=%b tick=%b div=%h exp 00 00 %h", OUTPUT_CLK, TICK,
                         ACTIVE_DIV, {16'd250, 16'd250});
    end
    step();
    hi = 0;
    for (int i = 0; i < 126; i++) begin
      step();
      checks++;
      if ({OUTPUT_CLK, TICK, ACTIVE_DIV} !== exp_vec()) begin
        errors++; $display("FAIL restart_model: got %h exp %h", {OUTPUT_CLK, TICK, ACTIVE_DIV}, exp_vec());
      end
      if (i < 125) hi += int'(OUTPUT_CLK[0]);
    end
    checks++;
    if (hi !== 125 || OUTPUT_CLK[0] !== 1'b0) begin
      errors++; $display("FAIL restart_high_phase: got hi=%0d last=%b exp 125 0", hi, OUTPUT_CLK[0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) EN = N_CH'($urandom);
      LOAD = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
      for (int c = 0; c < N_CH; c++) DIV[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
      RST = ($urandom_range(0, 499) == 0);
      step();
      checks++;
      if ({OUTPUT_CLK, TICK, ACTIVE_DIV} !== exp_vec()) begin
        errors++; $display("FAIL random_model: cycle %0d got %h exp %h", i,
                           {OUTPUT_CLK, TICK, ACTIVE_DIV}, exp_vec());
      end
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_ratio();
    test_idle_load();
    test_ratio_change();
    test_drain();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
